// File: rtl/poker_pkg.sv
// -----------------------------------------------------------------------------
// poker_pkg
// Shared types and constants for the card-dealing datapath.
//   card_t       : 6-bit card, {suit[5:4], rank[3:0]}
//   suit_t/rank_t: field types of card_t
//   RANK_MIN/MAX : legal rank range (ace = 1 .. king = 13)
//   NUM_SLOTS    : default number of hand slots
//   deal_state_t : deal controller FSM states
// -----------------------------------------------------------------------------
package poker_pkg;

    typedef logic [1:0] suit_t;
    typedef logic [3:0] rank_t;

    typedef struct packed {
        suit_t suit;
        rank_t rank;
    } card_t;

    localparam rank_t RANK_MIN  = 4'd1;
    localparam rank_t RANK_MAX  = 4'd13;
    localparam int    NUM_SLOTS = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DEAL  = 2'd2,
        ST_DONE  = 2'd3
    } deal_state_t;

endpackage

// File: rtl/card_checker.sv
// -----------------------------------------------------------------------------
// card_checker
// Purely combinational legality check for an offered card.
// Ports:
//   card_i       : offered card
//   shadow_i     : copies of the cards already stored in the hand
//   shadow_vld_i : per-slot flag, shadow_i[n] holds a card of this deal
//   rank_ok_o    : rank lies within RANK_MIN..RANK_MAX
//   dup_o        : card equals some valid shadow entry
// -----------------------------------------------------------------------------
module card_checker #(
    parameter int NUM_SLOTS = poker_pkg::NUM_SLOTS
) (
    input  poker_pkg::card_t                 card_i,
    input  poker_pkg::card_t [NUM_SLOTS-1:0] shadow_i,
    input  logic             [NUM_SLOTS-1:0] shadow_vld_i,
    output logic                             rank_ok_o,
    output logic                             dup_o
);
    import poker_pkg::*;

    always_comb begin
        rank_ok_o = (card_i.rank >= RANK_MIN) && (card_i.rank <= RANK_MAX);
        dup_o     = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (shadow_vld_i[i] && (shadow_i[i] == card_i)) begin
                dup_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/deal_controller.sv
// -----------------------------------------------------------------------------
// deal_controller
// Sequences one deal: zero the hand memory slot by slot, then accept cards
// from a valid/ready deck source, dropping illegal ranks and duplicates,
// until the hand is full.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start, abort       : begin a new deal / abandon the current one
//   card_valid/ready   : deck handshake, card_data carries the offered card
//   card_reject        : offered card dropped in this handshake cycle
//   mem_we/waddr/wdata : write port of the hand memory
//   slot_count         : cards accepted in this deal
//   busy, deal_done    : in CLEAR/DEAL, in DONE
//   reject_count       : saturating count of dropped cards since start
// -----------------------------------------------------------------------------
module deal_controller #(
    parameter int NUM_SLOTS = poker_pkg::NUM_SLOTS,
    parameter int REJ_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             card_valid,
    input  logic [5:0]       card_data,
    output logic             card_ready,
    output logic             card_reject,
    output logic             mem_we,
    output logic [2:0]       mem_waddr,
    output logic [5:0]       mem_wdata,
    output logic [2:0]       slot_count,
    output logic             busy,
    output logic             deal_done,
    output logic [REJ_W-1:0] reject_count
);
    import poker_pkg::*;

    localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOTS - 1);

    function automatic logic [REJ_W-1:0] sat_inc(input logic [REJ_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    deal_state_t            state_q, state_d;
    logic [2:0]             clr_cnt_q, clr_cnt_d;
    logic [2:0]             slot_cnt_q, slot_cnt_d;
    logic [REJ_W-1:0]       rej_cnt_q, rej_cnt_d;
    card_t [NUM_SLOTS-1:0]  shadow_q;
    logic [NUM_SLOTS-1:0]   shadow_vld_q, shadow_vld_d;

    logic                   shadow_we;
    logic                   ready_c;
    logic                   handshake;
    logic                   rank_ok;
    logic                   dup_hit;
    logic                   we_c;
    logic [2:0]             waddr_c;
    logic [5:0]             wdata_c;
    logic                   reject_c;
    card_t                  card_in;

    assign card_in   = card_t'(card_data);
    // Ready is a function of state alone so the source may wait on it.
    assign ready_c   = (state_q == ST_DEAL);
    assign handshake = card_valid & ready_c;

    card_checker #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_card_checker (
        .card_i       (card_in),
        .shadow_i     (shadow_q),
        .shadow_vld_i (shadow_vld_q),
        .rank_ok_o    (rank_ok),
        .dup_o        (dup_hit)
    );

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        slot_cnt_d   = slot_cnt_q;
        rej_cnt_d    = rej_cnt_q;
        shadow_vld_d = shadow_vld_q;
        shadow_we    = 1'b0;
        we_c         = 1'b0;
        waddr_c      = 3'd0;
        wdata_c      = 6'd0;
        reject_c     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // abort wins over a simultaneous start
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d      = ST_CLEAR;
                    clr_cnt_d    = 3'd0;
                    slot_cnt_d   = 3'd0;
                    rej_cnt_d    = '0;
                    shadow_vld_d = '0;
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    we_c      = 1'b1;
                    waddr_c   = clr_cnt_q;
                    clr_cnt_d = clr_cnt_q + 3'd1;
                    if (clr_cnt_q == LAST_SLOT) begin
                        state_d = ST_DEAL;
                    end
                end
            end
            ST_DEAL: begin
                // An aborted cycle neither writes nor counts the offered card.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (handshake) begin
                    if (rank_ok && !dup_hit) begin
                        we_c                     = 1'b1;
                        waddr_c                  = slot_cnt_q;
                        wdata_c                  = card_data;
                        shadow_we                = 1'b1;
                        shadow_vld_d[slot_cnt_q] = 1'b1;
                        slot_cnt_d               = slot_cnt_q + 3'd1;
                        if (slot_cnt_q == LAST_SLOT) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        reject_c  = 1'b1;
                        rej_cnt_d = sat_inc(rej_cnt_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= 3'd0;
            slot_cnt_q   <= 3'd0;
            rej_cnt_q    <= '0;
            shadow_vld_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            slot_cnt_q   <= slot_cnt_d;
            rej_cnt_q    <= rej_cnt_d;
            shadow_vld_q <= shadow_vld_d;
        end
    end

    // Shadow card values are only meaningful where shadow_vld_q is set,
    // so they carry no reset.
    always_ff @(posedge clk) begin
        if (shadow_we) begin
            shadow_q[slot_cnt_q] <= card_in;
        end
    end

    // Outputs are forced low while rst is held, not just after the edge.
    assign card_ready   = ~rst & ready_c;
    assign card_reject  = ~rst & reject_c;
    assign mem_we       = ~rst & we_c;
    assign mem_waddr    = rst ? 3'd0 : waddr_c;
    assign mem_wdata    = rst ? 6'd0 : wdata_c;
    assign slot_count   = rst ? 3'd0 : slot_cnt_q;
    assign busy         = ~rst & ((state_q == ST_CLEAR) || (state_q == ST_DEAL));
    assign deal_done    = ~rst & (state_q == ST_DONE);
    assign reject_count = rst ? '0 : rej_cnt_q;

endmodule
